// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle main-memory port between the instruction-fetch
// side (I) and the data-cache refill/write-through side (D).
//
// A single owner is picked while IDLE. Its command is latched at grant and held until
// mem_ack. Read data and a one-cycle done pulse are then returned to that owner only.
// Per-side stall outputs feed the hazard unit.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> on a tie, grant the side that did not own the previous transaction
//   undefined -> fixed priority, D wins every tie (I can starve under back-to-back D)
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    output logic                  i_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [STRB_WIDTH-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  d_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t                  state_q, state_d;
    logic                    last_owner_q, last_owner_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic                    grant_i;
    logic                    grant_d;

    // Arbitration: decide which requester would win if the port were free right now.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_owner_q == OWNER_I) begin
                grant_d = 1'b1;
            end else begin
                grant_i = 1'b1;
            end
`else
            grant_d = 1'b1;
`endif
        end else if (d_req) begin
            grant_d = 1'b1;
        end else if (i_req) begin
            grant_i = 1'b1;
        end
    end

    // Next-state logic: latch the winner's command at grant, return to IDLE on ack.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                end else if (grant_i) begin
                    state_d     = BUSY_I;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    state_d      = IDLE;
                    last_owner_d = OWNER_I;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d      = IDLE;
                    last_owner_d = OWNER_D;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_I;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    // Outputs: memory command from registers; done, rdata and stall react to mem_ack
    // in the same cycle so the pipeline can advance without an extra bubble.
    always_comb begin
        mem_req   = (state_q != IDLE);
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_wstrb = mem_wstrb_q;

        i_done    = (state_q == BUSY_I) && mem_ack;
        d_done    = (state_q == BUSY_D) && mem_ack;

        i_rdata   = i_done ? mem_rdata : '0;
        d_rdata   = (d_done && !mem_we_q) ? mem_rdata : '0;

        i_stall   = i_req & ~i_done;
        d_stall   = d_req & ~d_done;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter.
// The bench plays the memory (random latency and data) and predicts the owner of each
// transaction from the arbitration rule applied to its own request inputs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // Model state: 0 = I owned the last completed transaction, 1 = D did.
    bit model_last_d;
    bit obs_grant_d;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit predictWinnerD(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !model_last_d;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic applyStimulus(input bit ir, input logic [31:0] ia,
                                 input bit dr, input bit dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] ds);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        d_wstrb = ds;
    endtask

    // Play one memory transaction: wait for issue, check the command against the
    // predicted owner, ack after lat cycles, check done/rdata/stall, check the bubble.
    task automatic serve(input int lat, input logic [31:0] data, input bit keep, input bit drop_early);
        bit          win_d;
        bit          found;
        bit          exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rd;
        win_d     = predictWinnerD(i_req, d_req);
        exp_addr  = win_d ? d_addr : i_addr;
        exp_we    = win_d ? d_we : 1'b0;
        exp_wdata = d_wdata;
        exp_wstrb = win_d ? d_wstrb : 4'b0000;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("issue_seen", {31'd0, found}, 32'd1);
        if (!found) return;
        obs_grant_d = (mem_addr === d_addr) && (d_addr !== i_addr);
        checkOutput("mem_addr", mem_addr, exp_addr);
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        checkOutput("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
        if (drop_early) begin
            @(posedge clk);
            #1;
            if (win_d) d_req = 1'b0; else i_req = 1'b0;
            @(negedge clk);
            checkOutput("req_held_after_drop", {31'd0, mem_req}, 32'd1);
        end
        for (int k = 0; k < lat; k++) begin
            checkOutput("mem_req_hold", {31'd0, mem_req}, 32'd1);
            checkOutput("owner_stall", {31'd0, win_d ? d_stall : i_stall},
                        {31'd0, win_d ? d_req : i_req});
            @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        #1;
        exp_rd = (win_d && exp_we) ? 32'd0 : data;
        checkOutput("i_done", {31'd0, i_done}, {31'd0, !win_d});
        checkOutput("d_done", {31'd0, d_done}, {31'd0, win_d});
        checkOutput("i_rdata", i_rdata, win_d ? 32'd0 : exp_rd);
        checkOutput("d_rdata", d_rdata, win_d ? exp_rd : 32'd0);
        checkOutput("i_stall_ack", {31'd0, i_stall}, {31'd0, win_d ? i_req : 1'b0});
        checkOutput("d_stall_ack", {31'd0, d_stall}, {31'd0, win_d ? 1'b0 : d_req});
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        model_last_d = win_d;
        if (!keep) begin
            if (win_d) d_req = 1'b0; else i_req = 1'b0;
        end
        @(negedge clk);
        checkOutput("bubble_req", {31'd0, mem_req}, 32'd0);
        checkOutput("bubble_done", {30'd0, i_done, d_done}, 32'd0);
    endtask

    initial begin
        bit   [3:0] grants;
        bit   [3:0] exp_grants;
        bit         ir;
        bit         dr;
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        model_last_d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        checkOutput("rst_done", {30'd0, i_done, d_done}, 32'd0);

        $display("[TB] I-side read, ack 3 cycles after issue");
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        serve(3, 32'hDEAD_BEEF, 1'b0, 1'b0);

        $display("[TB] D-side write");
        applyStimulus(1'b0, 32'h0000_0200, 1'b1, 1'b1, 32'h0001_0004, 32'h1234_5678, 4'b0011);
        serve(1, 32'hCAFE_F00D, 1'b0, 1'b0);

        $display("[TB] D-side read, immediate ack");
        applyStimulus(1'b0, 32'h0000_0200, 1'b1, 1'b0, 32'h0002_0008, 32'h0, 4'b0000);
        serve(0, 32'h5555_AAAA, 1'b0, 1'b0);

        $display("[TB] four back-to-back tie rounds from reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last_d = 1'b0;
        applyStimulus(1'b1, 32'h0000_0A00, 1'b1, 1'b0, 32'h0000_0D00, 32'h0, 4'b0000);
        for (int r = 0; r < 4; r++) begin
            serve(r % 3, 32'h1000_0000 + r, 1'b1, 1'b0);
            grants[r] = obs_grant_d;
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_grants = 4'b0101;
`else
        exp_grants = 4'b1111;
`endif
        checkOutput("tie_grants", {28'd0, grants}, {28'd0, exp_grants});
        d_req = 1'b0;
        serve(0, 32'h0BAD_CAFE, 1'b1, 1'b0);
        i_req = 1'b0;
        @(negedge clk);

        $display("[TB] reset two cycles into a D transaction");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'b0000);
        for (int k = 0; k < 16 && !mem_req; k++) @(negedge clk);
        checkOutput("rst_case_issue", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last_d = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_req", {31'd0, mem_req}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        checkOutput("rst_mid_no_done", {30'd0, i_done, d_done}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_idle", {31'd0, mem_req}, 32'd0);

        $display("[TB] stray ack while idle");
        mem_ack = 1'b1;
        #1;
        checkOutput("idle_ack_no_done", {30'd0, i_done, d_done}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_ack_stay", {31'd0, mem_req}, 32'd0);

        $display("[TB] D drops request one cycle after grant");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_4444, 32'h0, 4'b0000);
        serve(2, 32'h4444_0000, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            ir = $urandom_range(0, 1);
            dr = ir ? bit'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(ir, {$urandom_range(0, 65535), 16'h0100}, dr, bit'($urandom_range(0, 1)),
                          {$urandom_range(0, 65535), 16'h0200}, $urandom, 4'($urandom_range(0, 15)));
            serve($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
            if (i_req || d_req) serve($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
